// File: rtl/moore_pkg.sv
// Shared types and defaults for the Moore-machine input conditioner.
package moore_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } token_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/moore_debounce.sv
// One conditioning channel: two-flop synchroniser followed by a stable-count debouncer.
module moore_debounce
  import moore_pkg::*;
#(
  parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level
);

  localparam logic [15:0] LAST_CNT = 16'(CYCLES - 1);

  logic        sync1_r;
  logic        sync2_r;
  logic        level_r;
  logic [15:0] cnt_r;

  // Synchroniser flops; they hold with the tile disabled so edges survive an ena-low window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else if (ena) begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stable-cycle counter: the level flips only after CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 16'd0;
      level_r <= 1'b0;
    end else if (ena) begin
      if (sync2_r != level_r) begin
        if (cnt_r == LAST_CNT) begin
          level_r <= sync2_r;
          cnt_r   <= 16'd0;
        end else begin
          cnt_r <= cnt_r + 16'd1;
        end
      end else begin
        cnt_r <= 16'd0;
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/moore_input_conditioner.sv
// Debounces a data pad and a step button and hands single-bit tokens to a Moore machine.
// Optional build macro MOORE_STEP_COUNT_EN adds an 8-bit accepted-token counter output.
module moore_input_conditioner
  import moore_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       din_raw,
  input  logic       step_raw,
  output logic       out_valid,
  output logic       out_bit,
  input  logic       out_ready,
  output logic       overrun,
  output logic       din_db
`ifdef MOORE_STEP_COUNT_EN
  ,
  output logic [7:0] step_count
`endif
);

  logic         din_db_s;
  logic         step_db_s;
  logic         step_prev_r;
  logic         step_edge_s;
  token_state_t state_r;
  token_state_t state_s;
  logic         out_bit_r;
  logic         out_bit_s;
  logic         overrun_r;
  logic         overrun_s;

  moore_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_din_db (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .raw   (din_raw),
    .level (din_db_s)
  );

  moore_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .raw   (step_raw),
    .level (step_db_s)
  );

  assign step_edge_s = step_db_s & ~step_prev_r;

  // Token next-state: a step while FULL is a refill only when the old token is consumed.
  always_comb begin
    state_s   = state_r;
    out_bit_s = out_bit_r;
    overrun_s = overrun_r;
    if (ena) begin
      case (state_r)
        EMPTY: begin
          if (step_edge_s) begin
            state_s   = FULL;
            out_bit_s = din_db_s;
          end else begin
            state_s = EMPTY;
          end
        end
        FULL: begin
          if (step_edge_s && out_ready) begin
            state_s   = FULL;
            out_bit_s = din_db_s;
          end else if (out_ready) begin
            state_s = EMPTY;
          end else if (step_edge_s) begin
            overrun_s = 1'b1;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Token register and step edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_bit_r   <= 1'b0;
      overrun_r   <= 1'b0;
      step_prev_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      out_bit_r <= out_bit_s;
      overrun_r <= overrun_s;
      if (ena) begin
        step_prev_r <= step_db_s;
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_bit   = out_bit_r;
  assign overrun   = overrun_r;
  assign din_db    = din_db_s;

`ifdef MOORE_STEP_COUNT_EN
  logic       accept_s;
  logic [7:0] step_count_r;

  assign accept_s = ena & step_edge_s & ((state_r == EMPTY) | out_ready);

  // Accepted-token counter, wrapping naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_count_r <= 8'd0;
    end else if (accept_s) begin
      step_count_r <= step_count_r + 8'd1;
    end
  end

  assign step_count = step_count_r;
`endif

endmodule
